// File: rtl/sram_arb_pkg.sv
// Shared types for the dual-master SRAM arbiter.
// Owner tags, response-pipeline entry and latency bound.
package sram_arb_pkg;

    typedef enum logic {
        OWNER_INSTR = 1'b0,
        OWNER_DATA  = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } rsp_entry_t;

    localparam int MAX_READ_LATENCY = 2;

endpackage

// File: rtl/sram_rsp_tracker.sv
// Read-response tracker: follows the SRAM read latency and
// steers sram_readdata to the master that issued each read.
module sram_rsp_tracker
    import sram_arb_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  rsp_entry_t        i_entry,
    input  logic [DATA_W-1:0] i_sram_readdata,
    output logic [DATA_W-1:0] o_i_readdata,
    output logic              o_i_readdatavalid,
    output logic [DATA_W-1:0] o_d_readdata,
    output logic              o_d_readdatavalid
);

    rsp_entry_t        r_pipe [READ_LATENCY];
    logic [DATA_W-1:0] r_i_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    rsp_entry_t        w_out;
    logic              w_i_hit;
    logic              w_d_hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < READ_LATENCY; k++) begin
                r_pipe[k] <= '0;
            end
        end else begin
            r_pipe[0] <= i_entry;
            for (int k = 1; k < READ_LATENCY; k++) begin
                r_pipe[k] <= r_pipe[k-1];
            end
        end
    end

    assign w_out   = r_pipe[READ_LATENCY-1];
    assign w_i_hit = w_out.valid && (w_out.owner == OWNER_INSTR);
    assign w_d_hit = w_out.valid && (w_out.owner == OWNER_DATA);

    // The non-owning master keeps showing its last returned word.
    assign o_i_readdatavalid = w_i_hit;
    assign o_d_readdatavalid = w_d_hit;
    assign o_i_readdata = w_i_hit ? i_sram_readdata : r_i_rdata;
    assign o_d_readdata = w_d_hit ? i_sram_readdata : r_d_rdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            r_i_rdata <= o_i_readdata;
            r_d_rdata <= o_d_readdata;
        end
    end

endmodule

// File: rtl/sram_dual_master_arbiter.sv
// Round-robin front-end sharing one SRAM port between the instruction
// and data masters. Optional stall counters: SRAM_ARB_STALL_CNT_EN.
module sram_dual_master_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W       = 15,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   i_address,
    input  logic                i_read,
    output logic                i_waitrequest,
    output logic [DATA_W-1:0]   i_readdata,
    output logic                i_readdatavalid,
    input  logic [ADDR_W-1:0]   d_address,
    input  logic                d_read,
    input  logic                d_write,
    input  logic [DATA_W/8-1:0] d_byteenable,
    input  logic [DATA_W-1:0]   d_writedata,
    output logic                d_waitrequest,
    output logic [DATA_W-1:0]   d_readdata,
    output logic                d_readdatavalid,
    output logic [ADDR_W-1:0]   sram_address,
    output logic                sram_chipselect,
    output logic                sram_write,
    output logic [DATA_W/8-1:0] sram_byteenable,
    output logic [DATA_W-1:0]   sram_writedata,
    output logic                sram_clken,
    input  logic [DATA_W-1:0]   sram_readdata
`ifdef SRAM_ARB_STALL_CNT_EN
    ,
    input  logic                stall_cnt_clr,
    output logic [31:0]         stall_cnt_i,
    output logic [31:0]         stall_cnt_d
`endif
);

    logic              r_ready;
    owner_e            r_rr_last;
    logic [ADDR_W-1:0] r_addr_hold;
    logic              w_d_any;
    logic              w_i_req;
    logic              w_d_req;
    logic              w_gnt_i;
    logic              w_gnt_d;
    rsp_entry_t        w_entry;

    assign w_d_any = d_read | d_write;
    assign w_i_req = r_ready & i_read;
    assign w_d_req = r_ready & w_d_any;

    // On contention the master that did not win last time goes first.
    assign w_gnt_d = w_d_req & (~w_i_req | (r_rr_last == OWNER_INSTR));
    assign w_gnt_i = w_i_req & ~w_gnt_d;

    assign i_waitrequest = ~r_ready | (i_read & ~w_gnt_i);
    assign d_waitrequest = ~r_ready | (w_d_any & ~w_gnt_d);
    assign sram_clken    = r_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ready     <= 1'b0;
            r_rr_last   <= OWNER_INSTR;
            r_addr_hold <= '0;
        end else begin
            r_ready     <= 1'b1;
            r_addr_hold <= sram_address;
            if (w_gnt_i || w_gnt_d) begin
                r_rr_last <= w_gnt_d ? OWNER_DATA : OWNER_INSTR;
            end
        end
    end

    always_comb begin
        sram_chipselect = 1'b0;
        sram_write      = 1'b0;
        sram_address    = r_addr_hold;
        sram_byteenable = '1;
        sram_writedata  = '0;
        unique case (1'b1)
            w_gnt_d: begin
                sram_chipselect = 1'b1;
                sram_write      = d_write;
                sram_address    = d_address;
                sram_writedata  = d_writedata;
                if (d_write) begin
                    sram_byteenable = d_byteenable;
                end
            end
            w_gnt_i: begin
                sram_chipselect = 1'b1;
                sram_address    = i_address;
            end
            default: ;
        endcase
    end

    // A simultaneous read+write is served as a write.
    assign w_entry.valid = w_gnt_i | (w_gnt_d & ~d_write);
    assign w_entry.owner = w_gnt_d ? OWNER_DATA : OWNER_INSTR;

    sram_rsp_tracker #(
        .DATA_W       (DATA_W),
        .READ_LATENCY (READ_LATENCY)
    ) u_rsp (
        .clk               (clk),
        .reset_n           (reset_n),
        .i_entry           (w_entry),
        .i_sram_readdata   (sram_readdata),
        .o_i_readdata      (i_readdata),
        .o_i_readdatavalid (i_readdatavalid),
        .o_d_readdata      (d_readdata),
        .o_d_readdatavalid (d_readdatavalid)
    );

`ifndef SYNTHESIS
    a_no_rw: assert property (@(posedge clk) disable iff (!reset_n)
        !(d_read && d_write));
`endif

`ifdef SRAM_ARB_STALL_CNT_EN
    logic [31:0] r_stall_i;
    logic [31:0] r_stall_d;
    logic        w_stall_i;
    logic        w_stall_d;

    assign w_stall_i = r_ready & i_read & i_waitrequest;
    assign w_stall_d = r_ready & w_d_any & d_waitrequest;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_i <= '0;
            r_stall_d <= '0;
        end else if (stall_cnt_clr) begin
            r_stall_i <= '0;
            r_stall_d <= '0;
        end else begin
            if (w_stall_i && (r_stall_i != '1)) begin
                r_stall_i <= r_stall_i + 32'd1;
            end
            if (w_stall_d && (r_stall_d != '1)) begin
                r_stall_d <= r_stall_d + 32'd1;
            end
        end
    end

    assign stall_cnt_i = r_stall_i;
    assign stall_cnt_d = r_stall_d;
`endif

endmodule

// File: tb/tb_sram_dual_master_arbiter.sv
// Self-checking bench: SRAM model plus a transaction-level reference
// of grants, memory contents and expected read responses.
module tb_sram_dual_master_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [14:0] i_address = '0;
    logic        i_read = 1'b0;
    logic        i_waitrequest;
    logic [31:0] i_readdata;
    logic        i_readdatavalid;
    logic [14:0] d_address = '0;
    logic        d_read = 1'b0;
    logic        d_write = 1'b0;
    logic [3:0]  d_byteenable = '0;
    logic [31:0] d_writedata = '0;
    logic        d_waitrequest;
    logic [31:0] d_readdata;
    logic        d_readdatavalid;
    logic [14:0] sram_address;
    logic        sram_chipselect;
    logic        sram_write;
    logic [3:0]  sram_byteenable;
    logic [31:0] sram_writedata;
    logic        sram_clken;
    logic [31:0] sram_rdata = '0;
`ifdef SRAM_ARB_STALL_CNT_EN
    logic        stall_cnt_clr = 1'b0;
    logic [31:0] stall_cnt_i;
    logic [31:0] stall_cnt_d;
`endif

    sram_dual_master_arbiter dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .i_address       (i_address),
        .i_read          (i_read),
        .i_waitrequest   (i_waitrequest),
        .i_readdata      (i_readdata),
        .i_readdatavalid (i_readdatavalid),
        .d_address       (d_address),
        .d_read          (d_read),
        .d_write         (d_write),
        .d_byteenable    (d_byteenable),
        .d_writedata     (d_writedata),
        .d_waitrequest   (d_waitrequest),
        .d_readdata      (d_readdata),
        .d_readdatavalid (d_readdatavalid),
        .sram_address    (sram_address),
        .sram_chipselect (sram_chipselect),
        .sram_write      (sram_write),
        .sram_byteenable (sram_byteenable),
        .sram_writedata  (sram_writedata),
        .sram_clken      (sram_clken),
        .sram_readdata   (sram_rdata)
`ifdef SRAM_ARB_STALL_CNT_EN
        ,
        .stall_cnt_clr   (stall_cnt_clr),
        .stall_cnt_i     (stall_cnt_i),
        .stall_cnt_d     (stall_cnt_d)
`endif
    );

    always #5 clk = ~clk;

    // Single-port SRAM with one cycle of read latency.
    logic [31:0] sram_mem [0:32767];
    always @(posedge clk) begin
        if (sram_chipselect) begin
            if (sram_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (sram_byteenable[b]) begin
                        sram_mem[sram_address][8*b +: 8] <=
                            sram_writedata[8*b +: 8];
                    end
                end
            end else begin
                sram_rdata <= sram_mem[sram_address];
            end
        end
    end

    typedef struct {
        int          due;
        bit          own_d;
        logic [31:0] data;
    } rsp_t;

    logic [31:0] ref_mem [0:32767];
    rsp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    bit          m_ready = 0;
    bit          m_last_d = 0;
    bit          last_gi;
    bit          last_gd;
    int          rdv_i_cnt = 0;
    int          rdv_d_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    task automatic preload(input int a, input logic [31:0] v);
        sram_mem[a] = v;
        ref_mem[a]  = v;
    endtask

    // One clock: check outputs against the reference, then commit it.
    task automatic cycle();
        bit          ir, dr, gi, gd, ei, ed;
        logic [31:0] eid, edd;
        @(negedge clk);
        ir = m_ready && i_read;
        dr = m_ready && (d_read || d_write);
        if (ir && dr) begin
            gd = !m_last_d;
            gi = m_last_d;
        end else begin
            gi = ir;
            gd = dr;
        end
        check("i_wait", i_waitrequest, !m_ready || (i_read && !gi));
        check("d_wait", d_waitrequest,
              !m_ready || ((d_read || d_write) && !gd));
        check("cs", sram_chipselect, gi || gd);
        check("we", sram_write, gd && d_write);
        check("clken", sram_clken, m_ready);
        if (gi) check("addr_i", sram_address, i_address);
        if (gd) begin
            check("addr_d", sram_address, d_address);
            check("be", sram_byteenable, d_write ? d_byteenable : 4'hF);
            if (d_write) check("wdata", sram_writedata, d_writedata);
        end
        ei = 0; ed = 0; eid = '0; edd = '0;
        for (int k = exp_q.size() - 1; k >= 0; k--) begin
            if (exp_q[k].due == cyc) begin
                if (exp_q[k].own_d) begin
                    ed = 1; edd = exp_q[k].data;
                end else begin
                    ei = 1; eid = exp_q[k].data;
                end
                exp_q.delete(k);
            end
        end
        check("i_rdv", i_readdatavalid, ei);
        if (ei) check("i_rdata", i_readdata, eid);
        check("d_rdv", d_readdatavalid, ed);
        if (ed) check("d_rdata", d_readdata, edd);
        if (i_readdatavalid) rdv_i_cnt++;
        if (d_readdatavalid) rdv_d_cnt++;
        last_gi = gi;
        last_gd = gd;
        @(posedge clk);
        if (reset_n) begin
            if (gi || gd) m_last_d = gd;
            if (gd && d_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (d_byteenable[b]) begin
                        ref_mem[d_address][8*b +: 8] = d_writedata[8*b +: 8];
                    end
                end
            end
            if (gi) exp_q.push_back('{cyc + 1, 1'b0, ref_mem[i_address]});
            if (gd && !d_write) begin
                exp_q.push_back('{cyc + 1, 1'b1, ref_mem[d_address]});
            end
            m_ready = 1;
        end
        cyc++;
        #1;
    endtask

    initial begin
        logic [5:0] gseq;
        bit         i_pend;
        bit         d_pend;
        int         kind;
        for (int a = 0; a < 32768; a++) preload(a, 32'h0);

        cycle();
        cycle();
        reset_n = 1'b1;
        cycle();
        cycle();

        // Continuous contention: data wins first after reset.
        preload(1, 32'h1111_0001);
        preload(2, 32'h2222_0002);
        rdv_i_cnt = 0;
        rdv_d_cnt = 0;
        gseq = '0;
        i_read = 1; i_address = 15'd1;
        d_read = 1; d_address = 15'd2;
        for (int k = 0; k < 6; k++) begin
            cycle();
            gseq = {gseq[4:0], last_gd};
        end
        i_read = 0;
        d_read = 0;
        cycle();
        check("grant_seq", gseq, 6'b101010);
        check("rdv_i_cnt", rdv_i_cnt, 3);
        check("rdv_d_cnt", rdv_d_cnt, 3);
`ifdef SRAM_ARB_STALL_CNT_EN
        check("stall_i", stall_cnt_i, 32'd3);
        check("stall_d", stall_cnt_d, 32'd3);
        stall_cnt_clr = 1'b1;
        cycle();
        stall_cnt_clr = 1'b0;
        check("stall_i_clr", stall_cnt_i, 32'd0);
        check("stall_d_clr", stall_cnt_d, 32'd0);
`endif

        // Lone instruction read.
        preload(16, 32'h1234_5678);
        i_read = 1; i_address = 15'h0010;
        cycle();
        i_read = 0;
        cycle();
        check("i_rd_hold", i_readdata, 32'h1234_5678);

        // Byte-masked write, then read back the merged word.
        d_write = 1; d_address = 15'h0020;
        d_writedata = 32'hAABB_CCDD; d_byteenable = 4'b0101;
        cycle();
        d_write = 0; d_read = 1;
        cycle();
        d_read = 0;
        cycle();
        check("d_rd_merge", d_readdata, 32'h00BB_00DD);

        // Reset lands while a read is in flight.
        i_read = 1; i_address = 15'h0010;
        cycle();
        i_read = 0;
        reset_n = 1'b0;
        m_ready = 0;
        m_last_d = 0;
        exp_q.delete();
        cycle();
        cycle();
        reset_n = 1'b1;
        cycle();
        cycle();

        // Random traffic obeying the hold-while-waiting rule.
        i_pend = 0;
        d_pend = 0;
        for (int n = 0; n < 500; n++) begin
            if (!i_pend) begin
                i_read = 1'($urandom_range(1, 0));
                i_address = 15'($urandom_range(15, 0));
                i_pend = i_read;
            end
            if (!d_pend) begin
                kind = $urandom_range(2, 0);
                d_read = (kind == 1);
                d_write = (kind == 2);
                d_address = 15'($urandom_range(15, 0));
                d_writedata = $urandom;
                d_byteenable = 4'($urandom_range(15, 0));
                d_pend = (kind != 0);
            end
            cycle();
            if (last_gi) i_pend = 0;
            if (last_gd) d_pend = 0;
        end
        i_read = 0;
        d_read = 0;
        d_write = 0;
        cycle();
        cycle();
        check("drain", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
